tx_frame_serializer: RTL and testbench



---
 rtl/tx_frame_serializer.sv | 158 +++++++++++++++
 tb/tb_tx_frame_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_serializer.sv
// TX serializer: bit-rate divider, code-word FIFO, start/data/stop framing and a 4-way output mux.
// Define TX_PARITY_EN to insert an even-parity bit between the LSB and the stop bit.
module tx_frame_serializer #(
  parameter int CLK_DIV    = 12500,
  parameter int CODE_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic                          callsign_bit,
  input  logic [CODE_W-1:0]             code_in,
  input  logic                          code_valid,
  output logic                          code_ready,
  output logic                          tx_out,
  output logic                          bit_tick,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW    = $clog2(CLK_DIV);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int IW    = $clog2(CODE_W);
  localparam int CNT_W = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [CW-1:0]     div_cnt;
  logic              bit_clk;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;
  state_t            state, next_state;
  logic [IW-1:0]     idx, next_idx;
  logic [CODE_W-1:0] shift, next_shift;
  logic              fsm_bit, mux_bit;

  assign bit_tick = (div_cnt == CW'(CLK_DIV - 1));
  assign bit_clk  = (div_cnt < CW'(CLK_DIV / 2));

  always_ff @(posedge CLOCK_50) begin
    if (reset || bit_tick) div_cnt <= '0;
    else                   div_cnt <= div_cnt + 1'b1;
  end

  // Readiness depends on occupancy only, so a pop never frees a slot for a same-cycle push.
  assign code_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push       = code_valid && code_ready;
  assign fifo_count = count;

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= code_in;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      shift <= next_shift;
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_shift = shift;
    pop        = 1'b0;
    fsm_bit    = 1'b0;
    case (state)
      START:   fsm_bit = 1'b1;
      DATA:    fsm_bit = shift[idx];
`ifdef TX_PARITY_EN
      PARITY:  fsm_bit = ^shift;
`endif
      default: fsm_bit = 1'b0;
    endcase
    if (mode != 2'b10) begin
      next_state = IDLE;
    end else if (bit_tick) begin
      case (state)
        IDLE, STOP: begin
          // STOP chains straight into the next START when a word is waiting.
          next_state = IDLE;
          if (count != '0) begin
            pop        = 1'b1;
            next_shift = mem[rd_ptr];
            next_state = START;
          end
        end
        START: begin
          next_state = DATA;
          next_idx   = IW'(CODE_W - 1);
        end
        DATA: begin
          if (idx == '0) begin
`ifdef TX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end else begin
            next_idx = idx - 1'b1;
          end
        end
`ifdef TX_PARITY_EN
        PARITY:  next_state = STOP;
`endif
        default: next_state = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    case (mode)
      2'b00:   mux_bit = callsign_bit;
      2'b01:   mux_bit = bit_clk;
      2'b10:   mux_bit = fsm_bit;
      default: mux_bit = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) tx_out <= 1'b0;
    else       tx_out <= mux_bit;
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: stimulus queues expected words, a line monitor decodes frames off tx_out.
module tb_tx_frame_serializer;
  localparam int CLK_DIV    = 8;
  localparam int CODE_W     = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = CODE_W + 2 + PAR;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        mode = 2'b11;
  logic              callsign_bit = 1'b0;
  logic [CODE_W-1:0] code_in = '0;
  logic              code_valid = 1'b0;
  logic              code_ready, tx_out, bit_tick, busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tx_frame_serializer #(.CLK_DIV(CLK_DIV), .CODE_W(CODE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .mode(mode), .callsign_bit(callsign_bit),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready), .tx_out(tx_out),
    .bit_tick(bit_tick), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;
  logic [CODE_W-1:0] exp_q[$];
  bit mon_en = 0;
  bit mon_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference frame: bit 0 is first on the line.
  function automatic logic [CODE_W+2:0] frame_of(input logic [CODE_W-1:0] w);
    logic [CODE_W+2:0] f = '0;
    f[0] = 1'b1;
    for (int i = 0; i < CODE_W; i++) f[1+i] = w[CODE_W-1-i];
    if (PAR == 1) f[CODE_W+1] = ($countones(w) % 2) == 1;
    return f;
  endfunction

  // Line monitor: hunt for a start bit, sample each bit mid-period.
  initial begin
    logic [CODE_W+2:0] got;
    logic [CODE_W-1:0] w;
    bit more;
    forever begin
      @(negedge CLOCK_50);
      if (mon_en && tx_out === 1'b1) begin
        mon_busy = 1;
        do begin
          got = '0;
          repeat (CLK_DIV/2) @(negedge CLOCK_50);
          for (int b = 0; b < FL; b++) begin
            if (b > 0) repeat (CLK_DIV) @(negedge CLOCK_50);
            got[b] = tx_out;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(got), 32'h0);
          end else begin
            w = exp_q.pop_front();
            chk("frame", 32'(got), 32'(frame_of(w)));
          end
          more = exp_q.size() != 0;
          if (more) begin
            repeat (CLK_DIV/2) @(negedge CLOCK_50);
            chk("b2b_start", 32'(tx_out), 32'h1);
          end
        end while (more && tx_out === 1'b1);
        mon_busy = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [CODE_W-1:0] w, input bit expect_tx);
    code_in = w;
    code_valid = 1'b1;
    if (expect_tx) exp_q.push_back(w);
    @(negedge CLOCK_50);
    code_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!bit_tick && n < 4*CLK_DIV);
    chk("tick_seen", 32'(bit_tick), 32'h1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 4000) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (2) @(negedge CLOCK_50);
    chk("drain_done", 32'(exp_q.size() == 0 && !mon_busy), 32'h1);
    chk("fifo_empty", 32'(fifo_count), 32'h0);
  endtask

  task automatic busy_len(input int want);
    int n = 0;
    while (!busy && n < 4*CLK_DIV) begin
      @(negedge CLOCK_50);
      n++;
    end
    n = 0;
    while (busy && n < 100*CLK_DIV) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("busy_len", 32'(n), 32'(want));
  endtask

  // Reset released on a negedge; the tick must close out the CLK_DIV-th cycle.
  task automatic first_tick_check();
    int n = 0;
    reset = 1'b0;
    while (!bit_tick && n < 4*CLK_DIV) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("first_tick_cycles", 32'(n + 1), 32'(CLK_DIV));
    @(negedge CLOCK_50);
    chk("tick_one_cycle", 32'(bit_tick), 32'h0);
  endtask

  initial begin
    logic cs;
    int nb;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_tx_out", 32'(tx_out), 32'h0);
    chk("rst_bit_tick", 32'(bit_tick), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_code_ready", 32'(code_ready), 32'h1);
    first_tick_check();

    // Bit clock: high for the first half of each period, one cycle late.
    wait_tick();
    mode = 2'b01;
    for (int k = 1; k <= 2*CLK_DIV; k++) begin
      @(negedge CLOCK_50);
      chk("bitclk", 32'(tx_out), 32'(((k + CLK_DIV - 2) % CLK_DIV) < CLK_DIV/2));
    end

    mode = 2'b00;
    for (int k = 0; k < 12; k++) begin
      cs = 1'($urandom_range(0, 1));
      callsign_bit = cs;
      @(negedge CLOCK_50);
      chk("callsign", 32'(tx_out), 32'(cs));
    end

    mode = 2'b11;
    @(negedge CLOCK_50);
    for (int k = 0; k < 8; k++) begin
      callsign_bit = 1'($urandom_range(0, 1));
      @(negedge CLOCK_50);
      chk("idle_low", 32'(tx_out), 32'h0);
    end

    mon_en = 1;
    mode = 2'b10;
    push(8'hA5, 1);
    busy_len(FL*CLK_DIV);
    wait_drain();

    push(8'h3C, 1);
    push(8'hFF, 1);
    busy_len(2*FL*CLK_DIV);
    wait_drain();

    for (int it = 0; it < 6; it++) begin
      nb = $urandom_range(1, FIFO_DEPTH);
      for (int j = 0; j < nb; j++) push(CODE_W'($urandom), 1);
      wait_drain();
    end

    // Fill with no frames running, overflow, then a push coincident with a pop.
    mode = 2'b11;
    for (int j = 0; j < FIFO_DEPTH; j++) push(CODE_W'($urandom), 1);
    chk("full_not_ready", 32'(code_ready), 32'h0);
    push(8'h11, 0);
    chk("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    wait_tick();
    mode = 2'b10;
    code_in = 8'h99;
    code_valid = 1'b1;
    @(negedge CLOCK_50);
    code_valid = 1'b0;
    chk("pop_push_count", 32'(fifo_count), 32'(FIFO_DEPTH - 1));
    chk("ready_after_pop", 32'(code_ready), 32'h1);
    wait_drain();

    // Abort mid-DATA, then a fresh word must go out whole.
    mon_en = 0;
    push(8'h5A, 0);
    wait_tick();
    wait_tick();
    wait_tick();
    chk("abort_busy_before", 32'(busy), 32'h1);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    mode = 2'b11;
    @(negedge CLOCK_50);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_tx", 32'(tx_out), 32'h0);
    chk("abort_fifo", 32'(fifo_count), 32'h0);
    push(8'hC3, 1);
    chk("push_in_idle_mode", 32'(fifo_count), 32'h1);
    mon_en = 1;
    mode = 2'b10;
    wait_drain();

    // Reset mid-frame clears everything and restarts the divider.
    mon_en = 0;
    push(8'h81, 0);
    push(8'h42, 0);
    wait_tick();
    wait_tick();
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk("mid_rst_fifo", 32'(fifo_count), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_tx", 32'(tx_out), 32'h0);
    first_tick_check();
    repeat (FL*CLK_DIV) @(negedge CLOCK_50);
    chk("mid_rst_no_frame", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
